// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single unified memory port
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iIReq,
    input  logic [DATA_W-1:0] iIAddr,
    output logic              oIDone,
    output logic [DATA_W-1:0] oIRdData,
    input  logic              iDReq,
    input  logic              iDWr,
    input  logic [DATA_W-1:0] iDAddr,
    input  logic [DATA_W-1:0] iDWrData,
    output logic              oDDone,
    output logic [DATA_W-1:0] oDRdData,
    output logic              oStallIF,
    output logic              oStallMEM,
    output logic              oMemReq,
    output logic              oMemWr,
    output logic [DATA_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWrData,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRdData,
    output logic              oErr
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] MAX_CNT = SW'(MAX_DSTREAK);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t        state, nextState;
    logic [SW-1:0] dStreak;
    logic          grantI, grantD;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Data wins ties unless the fetch has already been passed over MAX_DSTREAK times.
    always_comb begin
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                if (iDReq && !(iIReq && dStreak == MAX_CNT)) begin
                    grantD    = 1'b1;
                    nextState = BUSY_D;
                end else if (iIReq) begin
                    grantI    = 1'b1;
                    nextState = BUSY_I;
                end
            end
            BUSY_I:  if (iMemAck) nextState = RESP_I;
            BUSY_D:  if (iMemAck) nextState = RESP_D;
            RESP_I:  nextState = IDLE;
            RESP_D:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dStreak    <= '0;
            oMemReq    <= 1'b0;
            oMemWr     <= 1'b0;
            oMemAddr   <= '0;
            oMemWrData <= '0;
            oIRdData   <= '0;
            oDRdData   <= '0;
            oErr       <= 1'b0;
        end else begin
            if (grantI) begin
                oMemReq  <= 1'b1;
                oMemWr   <= 1'b0;
                oMemAddr <= iIAddr;
                dStreak  <= '0;
            end
            if (grantD) begin
                oMemReq    <= 1'b1;
                oMemWr     <= iDWr;
                oMemAddr   <= iDAddr;
                oMemWrData <= iDWrData;
                if (!iIReq)                dStreak <= '0;
                else if (dStreak != MAX_CNT) dStreak <= dStreak + SW'(1);
            end
            if (iMemAck) begin
                case (state)
                    BUSY_I: begin
                        oMemReq  <= 1'b0;
                        oIRdData <= iMemRdData;
                    end
                    BUSY_D: begin
                        oMemReq <= 1'b0;
                        if (!oMemWr) oDRdData <= iMemRdData;
                    end
                    default: oErr <= 1'b1;
                endcase
            end
        end
    end

    // Done pulses decode from registered state, keeping the memory ack off every output path.
    assign oIDone    = (state == RESP_I);
    assign oDDone    = (state == RESP_D);
    assign oStallIF  = iIReq & ~oIDone;
    assign oStallMEM = iDReq & ~oDDone;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a reference model
module tb_mem_arbiter;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        iIReq, iDReq, iDWr, iMemAck;
    logic [31:0] iIAddr, iDAddr, iDWrData, iMemRdData;
    logic        oIDone, oDDone, oStallIF, oStallMEM, oMemReq, oMemWr, oErr;
    logic [31:0] oIRdData, oDRdData, oMemAddr, oMemWrData;

    int          vectors = 0;
    int          miscompares = 0;
    int          mStreak = 0;
    logic [31:0] mIRd = '0, mDRd = '0;
    logic        mErr = 1'b0;

    mem_arbiter #(.DATA_W(32), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .iIReq(iIReq), .iIAddr(iIAddr), .oIDone(oIDone), .oIRdData(oIRdData),
        .iDReq(iDReq), .iDWr(iDWr), .iDAddr(iDAddr), .iDWrData(iDWrData),
        .oDDone(oDDone), .oDRdData(oDRdData),
        .oStallIF(oStallIF), .oStallMEM(oStallMEM),
        .oMemReq(oMemReq), .oMemWr(oMemWr), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
        .iMemAck(iMemAck), .iMemRdData(iMemRdData), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iIReq = 0; iDReq = 0; iDWr = 0; iMemAck = 0;
        iIAddr = '0; iDAddr = '0; iDWrData = '0; iMemRdData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mStreak = 0; mIRd = '0; mDRd = '0; mErr = 1'b0;
    endtask

    // Entered at a negedge with the arbiter idle and at least one request raised.
    task automatic run_txn(input int lat, input logic [31:0] rd, input bit dropEarly, output bit gotI);
        bit          expI;
        logic [31:0] eAddr, eWd;
        logic        eWr;
        expI = iIReq && (!iDReq || mStreak == MAXD);
        eWd  = '0;
        if (expI) begin
            eAddr = iIAddr; eWr = 1'b0; mStreak = 0;
        end else begin
            eAddr = iDAddr; eWr = iDWr; eWd = iDWrData;
            mStreak = iIReq ? ((mStreak < MAXD) ? mStreak + 1 : MAXD) : 0;
        end
        @(negedge clk);
        check("grant_req", oMemReq, 1);
        check("grant_addr", oMemAddr, eAddr);
        check("grant_wr", oMemWr, eWr);
        if (!expI) check("grant_wdata", oMemWrData, eWd);
        check("busy_stallIF", oStallIF, iIReq);
        check("busy_stallMEM", oStallMEM, iDReq);
        if (dropEarly) begin
            if (expI) iIReq = 0; else iDReq = 0;
        end
        repeat (lat) @(negedge clk);
        check("busy_hold", {oMemReq, oMemWr, oMemAddr}, {1'b1, eWr, eAddr});
        check("busy_nodone", {oIDone, oDDone}, 2'b00);
        iMemAck = 1'b1; iMemRdData = rd;
        @(negedge clk);
        iMemAck = 1'b0; iMemRdData = $urandom;
        if (expI) mIRd = rd;
        else if (!eWr) mDRd = rd;
        check("resp_doneI", oIDone, expI);
        check("resp_doneD", oDDone, !expI);
        check("resp_req", oMemReq, 0);
        check("resp_irdata", oIRdData, mIRd);
        check("resp_drdata", oDRdData, mDRd);
        check("resp_stallIF", oStallIF, iIReq && !expI);
        gotI = oIDone;
        if (expI) iIReq = 0; else iDReq = 0;
        @(negedge clk);
        check("idle_done", {oIDone, oDDone, oMemReq}, 3'b000);
        check("idle_err", oErr, mErr);
    endtask

    initial begin
        bit          g;
        logic [5:0]  order;
        int          dIssued;

        // Reset state
        do_reset();
        check("rst_ctrl", {oMemReq, oMemWr, oIDone, oDDone, oErr}, 5'b0);
        check("rst_data", {oMemAddr, oMemWrData, oIRdData, oDRdData}, 128'b0);

        // Lone fetch
        iIReq = 1; iIAddr = 32'h40;
        run_txn(2, 32'h8C220004, 0, g);
        check("fetch_data", oIRdData, 32'h8C220004);

        // Load 0x11, then store that must leave it untouched
        iDReq = 1; iDWr = 0; iDAddr = 32'h80;
        run_txn(0, 32'h11, 0, g);
        iDReq = 1; iDWr = 1; iDAddr = 32'h200; iDWrData = 32'hDEADBEEF;
        run_txn(1, 32'h5555AAAA, 0, g);
        check("store_keeps_load", oDRdData, 32'h11);

        // Simultaneous: data first, then fetch
        iIReq = 1; iIAddr = 32'h44; iDReq = 1; iDWr = 0; iDAddr = 32'h100;
        run_txn(1, 32'hCAFE0001, 0, g);
        check("sim_first_is_d", g, 0);
        run_txn(0, 32'h12345678, 0, g);
        check("sim_second_is_i", g, 1);

        // Starvation: fetch held against five back-to-back loads
        do_reset();
        iIReq = 1; iIAddr = 32'h1000;
        dIssued = 0; order = '0;
        for (int k = 0; k < 6; k++) begin
            if (!iDReq && dIssued < 5) begin
                iDReq = 1; iDWr = 0; iDAddr = 32'h2000 + 32'(dIssued * 4); dIssued++;
            end
            run_txn(k % 3, $urandom, 0, g);
            order = {order[4:0], g};
        end
        check("starve_order", order, 6'b000010);

        // Randomized traffic, including early request withdrawal
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (!iIReq && ($urandom % 2 == 0)) begin
                iIReq = 1; iIAddr = $urandom;
            end
            if (!iDReq && ($urandom % 10 < 7)) begin
                iDReq = 1; iDWr = 1'($urandom); iDAddr = $urandom; iDWrData = $urandom;
            end
            if (!iIReq && !iDReq) begin
                iDReq = 1; iDWr = 0; iDAddr = $urandom;
            end
            run_txn($urandom_range(0, 3), $urandom, ($urandom % 4 == 0), g);
        end
        iIReq = 0; iDReq = 0;

        // Spurious ack while idle
        do_reset();
        iMemAck = 1; iMemRdData = 32'hBAD;
        @(negedge clk);
        iMemAck = 0;
        mErr = 1'b1;
        check("spur_err", oErr, 1);
        check("spur_idle", {oMemReq, oIDone, oDDone}, 3'b000);
        repeat (3) @(negedge clk);
        check("spur_sticky", oErr, 1);
        iIReq = 1; iIAddr = 32'h300;
        run_txn(0, 32'h77, 0, g);

        // Reset during a data access, then a late ack
        do_reset();
        check("rst_clears_err", oErr, 0);
        iDReq = 1; iDWr = 1; iDAddr = 32'h400; iDWrData = 32'hABCD;
        @(negedge clk);
        check("rb_busy", {oMemReq, oMemWr}, 2'b11);
        reset = 1; iDReq = 0;
        @(negedge clk);
        reset = 0;
        check("rb_outputs", {oMemReq, oMemWr, oMemAddr, oMemWrData, oIDone, oDDone, oErr}, 69'b0);
        iMemAck = 1;
        @(negedge clk);
        iMemAck = 0;
        check("rb_late_ack_err", oErr, 1);
        check("rb_no_done", {oDDone, oIDone, oMemReq}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of data and address buses.
REQ-002 Parameter MAX_DSTREAK, default 4, number of consecutive data grants allowed while a fetch waits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iIReq  input  1  instruction-fetch request level; held until oIDone.
REQ-006 iIAddr  input  DATA_W  fetch address; stable while iIReq is high.
REQ-007 oIDone  output  1  one-cycle pulse; fetch complete and oIRdData valid.
REQ-008 oIRdData  output  DATA_W  fetched instruction; holds its value until the next fetch completes.
REQ-009 iDReq  input  1  data-access request level; held until oDDone.
REQ-010 iDWr  input  1  1 = store, 0 = load; stable while iDReq is high.
REQ-011 iDAddr  input  DATA_W  data address; stable while iDReq is high.
REQ-012 iDWrData  input  DATA_W  store data.
REQ-013 oDDone  output  1  one-cycle pulse; access complete.
REQ-014 oDRdData  output  DATA_W  load data; holds its value until the next load completes.
REQ-015 oStallIF  output  1  iIReq & ~oIDone; stalls fetch.
REQ-016 oStallMEM  output  1  iDReq & ~oDDone; stalls the memory stage.
REQ-017 oMemReq  output  1  registered request to the unified memory; level-held until iMemAck.
REQ-018 oMemWr  output  1  registered write enable to the unified memory.
REQ-019 oMemAddr  output  DATA_W  registered address to the unified memory.
REQ-020 oMemWrData  output  DATA_W  registered write data to the unified memory.
REQ-021 iMemAck  input  1  one-cycle completion from memory.
REQ-022 iMemRdData  input  DATA_W  read data; valid with iMemAck.
REQ-023 oErr  output  1  sticky protocol-error flag.

Function
REQ-024 The FSM SHALL have exactly the states IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
REQ-025 In IDLE with only iIReq high, the block SHALL go to BUSY_I.
REQ-026 In IDLE with only iDReq high, the block SHALL go to BUSY_D.
REQ-027 In IDLE with both requests high, the block SHALL go to BUSY_D unless the streak counter equals MAX_DSTREAK, in which case it SHALL go to BUSY_I.
REQ-028 On entering BUSY_x, the block SHALL register oMemReq=1 and load oMemAddr from the granted requester; for BUSY_D it SHALL also load oMemWr=iDWr and oMemWrData=iDWrData.
REQ-029 On entering BUSY_I, the block SHALL register oMemWr=0.
REQ-030 In BUSY_x, the block SHALL hold all memory outputs stable until a cycle with iMemAck=1.
REQ-031 On iMemAck in BUSY_x, the block SHALL move to RESP_x and clear oMemReq; in the same edge it SHALL capture iMemRdData into oIRdData (BUSY_I) or into oDRdData (BUSY_D load only).
REQ-032 On a store completion, oDRdData SHALL be unchanged.
REQ-033 In RESP_x, the block SHALL assert oxDone for that one cycle only and SHALL go to IDLE on the next edge, regardless of the inputs.
REQ-034 Minimum turnaround SHALL be 3 cycles from the IDLE sample to the next IDLE: an ack in the first BUSY cycle gives done on cycle 2.
REQ-035 The streak counter (width clog2(MAX_DSTREAK+1)) SHALL increment on a D grant made while iIReq=1, saturating at MAX_DSTREAK.
REQ-036 The streak counter SHALL clear on every I grant and on any D grant made while iIReq=0.
REQ-037 oErr SHALL set when iMemAck=1 in IDLE, RESP_I or RESP_D; the ack SHALL otherwise be ignored, and oErr SHALL clear only on reset.
REQ-038 A requester deasserting its request while in BUSY SHALL NOT abort the transaction; done SHALL still pulse.
REQ-039 The block SHALL have no combinational path from iMemAck or iMemRdData to any output.

Reset
REQ-040 Reset SHALL force IDLE, clear the streak counter to 0 and drive oMemReq, oMemWr, oIDone, oDDone and oErr to 0.
REQ-041 Reset SHALL clear oMemAddr, oMemWrData, oIRdData and oDRdData to 0.
REQ-042 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse; a late iMemAck after reset SHALL set oErr.

Verification
REQ-043 Lone fetch: iIReq=1, iIAddr=0x40, ack 2 cycles after oMemReq rises with data 0x8C220004 -> oMemAddr=0x40, oMemWr=0; one oIDone pulse; oIRdData=0x8C220004; oStallIF high until the done cycle.
REQ-044 Simultaneous requests (iIReq, and iDReq load at 0x100) -> data serviced first; oStallIF stays high; fetch issued in the IDLE cycle after RESP_D.
REQ-045 Starvation: iIReq held, 5 back-to-back data requests with MAX_DSTREAK=4 -> grant order D,D,D,D,I,D.
REQ-046 Store iDWr=1, iDAddr=0x200, iDWrData=0xDEADBEEF, prior oDRdData=0x11 -> oMemWr=1 with the given address and data; oDDone pulses; oDRdData stays 0x11.
REQ-047 Spurious iMemAck in IDLE -> oErr=1 and remains 1 until reset; FSM stays in IDLE.
REQ-048 Reset asserted in BUSY_D -> next cycle IDLE with all outputs 0; no oDDone pulse.
